systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Drives the top and left edges of an N x N weight-stationary PE array: the transmit side of the array's load_w/w_in/a_in/sum_in interface.
- Buffers N weight rows and replays them down the PE weight shift chain in the order that chain requires.
- Then accepts activation vectors over valid/ready and applies diagonal skew, so row r of the array sees its element r cycles late.
- Sits between the layer sequencer/SRAM readers and the PE array.

Parameters:
- DW, 16, data width of each weight/activation/sum element
- N, 4, array dimension (rows = columns = N), N >= 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- w_valid  in  1  weight row valid
- w_ready  out  1  weight row accepted when w_valid & w_ready
- w_data  in  N*DW  one weight row; bits [(c+1)*DW-1:c*DW] = weight for column c
- a_valid  in  1  activation vector valid
- a_ready  out  1  activation vector accepted when a_valid & a_ready
- a_data  in  N*DW  activation vector; slice r = element for array row r
- a_last  in  1  qualifies final vector of the stream
- load_w  out  1  global weight-load enable to all PEs
- w_col  out  N*DW  to top-row PE w_in, slice c = column c
- a_row  out  N*DW  to left-column PE a_in, slice r = row r
- a_row_vld  out  N  bit r = a_row slice r carries real data (for the drain side)
- sum_top  out  N*DW  to top-row PE sum_in, slice c
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when FLUSH completes

Behaviour:
- All registers are synchronous; reset is active-low and sampled on the rising edge of clk.
- Reset values: FSM=IDLE, load_w=0, w_col=0, a_row=0, a_row_vld=0, sum_top=0, w_ready=0, a_ready=0, busy=0, done=0, row counters=0.
- Reset asserted mid-operation aborts immediately. The weight buffer contents are don't-care and are not cleared.
- All outputs are registered.
- FSM states:
  - IDLE: w_ready=1. First accepted row goes to buffer slot 0, row counter = 1, go to WBUF.
  - WBUF: w_ready=1. Each accepted row goes to slot row_cnt and row_cnt increments. After row N-1 is accepted: w_ready=0, go to LOAD.
  - LOAD: exactly 2N cycles with load_w=1. At load cycle c (0..2N-1), w_col = buffer row N-1-floor(c/2). Each row is held 2 cycles, because the PE chain advances 2 registers per row. After the final cycle, array row k holds weight row k. a_row=0 and a_row_vld=0 throughout. Go to STREAM with load_w=0.
  - STREAM: a_ready=1.
    - Accepted vector at edge t: a_row slice r = element r, and a_row_vld[r]=1, on the output at edge t+1+r.
    - Cycles with no accepted vector inject zero with vld bit 0 at skew stage 0 (bubble preserved through the skew).
    - Accepting the vector with a_last=1 sets a_ready=0 and moves to FLUSH.
  - FLUSH: no input is accepted. The skew pipeline shifts for N-1 more cycles, then zeros. done pulses on the cycle after the last valid lane drains (a_row_vld returns to all-zero). Return to IDLE.
- Skew implementation: row r has an r-stage delay line of DW+1 bits (data + vld). Row 0 has no extra delay.
- Streams of length 1 are legal: a_last on the first vector gives FLUSH immediately.
- a_last is ignored unless a_valid & a_ready.
- w_valid in STREAM/LOAD/FLUSH is not accepted (w_ready=0). It is held by the upstream.
- sum_top = 0 in all states, unless the optional feature below is enabled.
- No arithmetic is performed. Widths pass through unchanged.

Optional Feature:
- Macro FEEDER_BIAS_EN.
- Defined:
  - One extra row is accepted after the N weight rows (WBUF counts to N+1). That row is the bias vector.
  - sum_top slice c = bias[c] during STREAM and FLUSH, 0 otherwise.
  - The bias register resets to 0.
- Undefined:
  - Exactly N rows are accepted.
  - sum_top is constant 0 and no bias storage is built.

Test Plan (N=4, DW=16):
- Weight load: rows R0..R3 with slice c = 16*r + c, presented back-to-back → w_ready drops after R3. load_w is high for exactly 8 cycles. w_col sequence is R3,R3,R2,R2,R1,R1,R0,R0. A 4x4 behavioural PE-chain model ends holding row k = Rk.
- Skew: single vector a_data = {4,3,2,1} with a_last accepted at edge t → a_row slice 0 = 1 at t+1, slice 1 = 2 at t+2, slice 2 = 3 at t+3, slice 3 = 4 at t+4. Each vld bit is high for exactly one cycle. done pulses at t+5. busy drops to 0 the same cycle.
- Bubbles: a_valid pattern 1,0,1 with vectors A, B → slice 0 vld pattern 1,0,1. Slice 3 shows the same pattern delayed by 3 cycles. The bubble lane data is 0.
- Backpressure: w_valid held high during STREAM → no extra weight row is captured. load_w stays 0 until the next IDLE→LOAD cycle.
- Reset mid-LOAD: rst_n low for 1 cycle at load cycle 3 → next cycle load_w=0, busy=0, w_ready=1. A fresh 4-row load then completes correctly.
- FEEDER_BIAS_EN: 5th row = {40,30,20,10} → sum_top = {40,30,20,10} throughout STREAM/FLUSH, and 0 in IDLE/LOAD.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder
// Edge feeder for an N x N weight-stationary PE array.
//   - Buffers N weight rows from w_valid/w_ready. It then replays them on w_col
//     with load_w high for 2N cycles. The order is row N-1 first, and each row
//     is held for two cycles to match the PE weight shift chain.
//   - It then streams activation vectors from a_valid/a_ready onto a_row with
//     diagonal skew, so lane r lags lane 0 by r cycles. a_row_vld marks the
//     lanes that carry real data. Idle stream cycles travel through the skew
//     as zero bubbles.
//   - After the vector flagged a_last, the skew drains and done pulses once.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   w_valid/w_ready/w_data        weight row input (slice c = column c)
//   a_valid/a_ready/a_data/a_last activation input (slice r = array row r)
//   load_w, w_col       weight-load enable and top-row weight bus
//   a_row, a_row_vld    skewed left-column activations and lane valids
//   sum_top             top-row partial-sum input
//   busy, done          not-idle flag and end-of-flush pulse
// Optional build macro FEEDER_BIAS_EN:
//   When defined, one extra row is accepted after the weights. That row is
//   the bias vector, and it is driven on sum_top during STREAM/FLUSH.
//   When undefined, sum_top is constant zero.
module systolic_feeder #(
  parameter int DW = 16,
  parameter int N  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [N*DW-1:0] a_data,
  input  logic            a_last,
  output logic            load_w,
  output logic [N*DW-1:0] w_col,
  output logic [N*DW-1:0] a_row,
  output logic [N-1:0]    a_row_vld,
  output logic [N*DW-1:0] sum_top,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(2*N + 2);
`ifdef FEEDER_BIAS_EN
  localparam int NROWS = N + 1;
`else
  localparam int NROWS = N;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WBUF   = 3'd1,
    LOAD   = 3'd2,
    STREAM = 3'd3,
    FLUSH  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            w_ready_q, w_ready_d;
  logic            a_ready_q, a_ready_d;
  logic            load_w_q, load_w_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N*DW-1:0] w_col_q, w_col_d;
  logic [N*DW-1:0] a_row_q, a_row_d;
  logic [N-1:0]    a_row_vld_q, a_row_vld_d;
  logic [N*DW-1:0] sum_top_q, sum_top_d;
  logic [N*DW-1:0] wbuf_q [N];
  logic [N*DW-1:0] wbuf_d [N];
`ifdef FEEDER_BIAS_EN
  logic [N*DW-1:0] bias_q, bias_d;
`endif

  logic            w_fire_s;
  logic            a_fire_s;
  logic [CW-1:0]   ld_sel_s;

  assign w_fire_s = w_valid & w_ready_q;
  assign a_fire_s = a_valid & a_ready_q;
  // During LOAD, cnt_q is the current load cycle. The next cycle shows row
  // floor((cnt_q+1)/2), counted from the bottom of the buffer.
  assign ld_sel_s = (cnt_q + CW'(1)) >> 1;

  // Next-state, buffer writes and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    w_col_d = '0;
    done_d  = 1'b0;
`ifdef FEEDER_BIAS_EN
    bias_d  = bias_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_fire_s) begin
          wbuf_d[0] = w_data;
          cnt_d     = CW'(1);
          state_d   = WBUF;
        end else begin
          cnt_d = '0;
        end
      end
      WBUF: begin
        if (w_fire_s) begin
          for (int i = 1; i < N; i++) begin
            wbuf_d[i] = (cnt_q == CW'(i)) ? w_data : wbuf_q[i];
          end
`ifdef FEEDER_BIAS_EN
          bias_d = (cnt_q == CW'(N)) ? w_data : bias_q;
`endif
          if (cnt_q == CW'(NROWS - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
            // Load cycle 0 shows row N-1. Without bias that row is arriving
            // now, so bypass the buffer.
`ifdef FEEDER_BIAS_EN
            w_col_d = wbuf_q[N-1];
`else
            w_col_d = w_data;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOAD: begin
        if (cnt_q == CW'(2*N - 1)) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          for (int i = 0; i < N; i++) begin
            w_col_d = (ld_sel_s == CW'(N - 1 - i)) ? wbuf_q[i] : w_col_d;
          end
        end
      end
      STREAM: begin
        if (a_fire_s && a_last) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      FLUSH: begin
        // The last vector leaves lane N-1 N cycles after acceptance. Finish
        // on the following edge, when every lane valid returns to zero.
        if (cnt_q == CW'(N)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    w_ready_d = (state_d == IDLE) || (state_d == WBUF);
    a_ready_d = (state_d == STREAM);
    load_w_d  = (state_d == LOAD);
    busy_d    = (state_d != IDLE);
`ifdef FEEDER_BIAS_EN
    sum_top_d = ((state_d == STREAM) || (state_d == FLUSH)) ? bias_d : '0;
`else
    sum_top_d = '0;
`endif
  end

  // Skew lanes: lane r is an r+1 deep shift of {vld, data} and feeds a_row slice r
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [DW:0] sh_q [r+1];
    logic [DW:0] sh_d [r+1];

    // Stage 0 takes the accepted element or a zero bubble; later stages shift
    always_comb begin
      sh_d[0] = a_fire_s ? {1'b1, a_data[r*DW +: DW]} : '0;
      for (int k = 1; k <= r; k++) begin
        sh_d[k] = sh_q[k-1];
      end
    end

    // Lane shift register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          sh_q[k] <= '0;
        end
      end else begin
        sh_q <= sh_d;
      end
    end

    assign a_row_d[r*DW +: DW] = sh_q[r][DW-1:0];
    assign a_row_vld_d[r]      = sh_q[r][DW];
  end

  // Weight buffer storage: contents are don't-care after reset
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

`ifdef FEEDER_BIAS_EN
  // Bias row register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bias_q <= '0;
    end else begin
      bias_q <= bias_d;
    end
  end
`endif

  // FSM state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      load_w_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_col_q     <= '0;
      a_row_q     <= '0;
      a_row_vld_q <= '0;
      sum_top_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_ready_q   <= w_ready_d;
      a_ready_q   <= a_ready_d;
      load_w_q    <= load_w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      w_col_q     <= w_col_d;
      a_row_q     <= a_row_d;
      a_row_vld_q <= a_row_vld_d;
      sum_top_q   <= sum_top_d;
    end
  end

  assign w_ready   = w_ready_q;
  assign a_ready   = a_ready_q;
  assign load_w    = load_w_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign w_col     = w_col_q;
  assign a_row     = a_row_q;
  assign a_row_vld = a_row_vld_q;
  assign sum_top   = sum_top_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard testbench for systolic_feeder (N=4, DW=16).
// Stimulus pushes the expected values into queues:
//   - w_col words for each load cycle
//   - per-lane {arrival cycle, data} entries
//   - done cycles
// A negedge monitor pops and compares these whenever the DUT presents load_w,
// a_row_vld or done. The monitor also keeps a 2N-deep PE weight chain model.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            w_valid;
  logic            w_ready;
  logic [N*DW-1:0] w_data;
  logic            a_valid;
  logic            a_ready;
  logic [N*DW-1:0] a_data;
  logic            a_last;
  logic            load_w;
  logic [N*DW-1:0] w_col;
  logic [N*DW-1:0] a_row;
  logic [N-1:0]    a_row_vld;
  logic [N*DW-1:0] sum_top;
  logic            busy;
  logic            done;

  systolic_feeder #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .load_w(load_w), .w_col(w_col), .a_row(a_row), .a_row_vld(a_row_vld),
    .sum_top(sum_top), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [N*DW-1:0] wq [$];
  logic [63:0]     lq [N][$];
  int              dq [$];
  logic [N*DW-1:0] ch [2*N];
  int              ldcnt = 0;
  logic            bp = 1'b0;
  logic [N*DW-1:0] bias_row;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] mkrow(input int base, input int k);
    logic [N*DW-1:0] r;
    for (int c = 0; c < N; c++) r[c*DW +: DW] = DW'(base + 16*k + c);
    return r;
  endfunction

  // Monitor: pops expectations when the DUT presents an output
  always @(negedge clk) begin
    logic [63:0] e;
    if (load_w) begin
      ldcnt++;
      for (int i = 2*N-1; i > 0; i--) ch[i] = ch[i-1];
      ch[0] = w_col;
      if (wq.size() == 0) chk("w_col_extra", 64'(wq.size()), 64'd1);
      else chk("w_col", w_col, wq.pop_front());
    end
    for (int r = 0; r < N; r++) begin
      if (a_row_vld[r]) begin
        if (lq[r].size() == 0) chk("lane_extra", 64'(lq[r].size()), 64'd1);
        else begin
          e = lq[r].pop_front();
          chk($sformatf("lane%0d_data", r), 64'(a_row[r*DW +: DW]), {48'd0, e[15:0]});
          chk($sformatf("lane%0d_cycle", r), 64'(cyc), {32'd0, e[63:32]});
        end
      end else begin
        chk($sformatf("lane%0d_bubble_zero", r), 64'(a_row[r*DW +: DW]), 64'd0);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("done_extra", 64'(dq.size()), 64'd1);
      else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      chk("busy_at_done", 64'(busy), 64'd0);
    end
`ifdef FEEDER_BIAS_EN
    if (a_ready || (|a_row_vld)) chk("sum_top_bias", sum_top, bias_row);
    else if (load_w || w_ready) chk("sum_top_zero", sum_top, 64'd0);
`else
    chk("sum_top_zero", sum_top, 64'd0);
`endif
  end

  task automatic send_w(input logic [N*DW-1:0] d);
    int n = 0;
    w_valid = 1'b1;
    w_data  = d;
    while (!w_ready && n < 50) begin tick(); n++; end
    chk("w_ready_wait", 64'(w_ready), 64'd1);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [N*DW-1:0] d, input logic v, input logic last);
    int n = 0;
    int t;
    a_data  = d;
    a_valid = v;
    a_last  = last;
    if (bp) begin
      chk("bp_w_ready", 64'(w_ready), 64'd0);
      chk("bp_load_w", 64'(load_w), 64'd0);
    end
    while (!a_ready && n < 50) begin tick(); n++; end
    chk("a_ready_wait", 64'(a_ready), 64'd1);
    t = cyc + 1;
    if (v) begin
      for (int r = 0; r < N; r++) lq[r].push_back({32'(t + 1 + r), 16'd0, d[r*DW +: DW]});
      if (last) dq.push_back(t + N + 1);
    end
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (dq.size() != 0 && n < 40) begin tick(); n++; end
    chk("done_wait", 64'(dq.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_w_ready", 64'(w_ready), 64'd1);
  endtask

  task automatic load_rows(input int base, input int abort_at);
    int n = 0;
    wq.delete();
    ldcnt = 0;
    for (int i = 0; i < 2*N; i++) ch[i] = '0;
    for (int k = N-1; k >= 0; k--) begin
      wq.push_back(mkrow(base, k));
      wq.push_back(mkrow(base, k));
    end
    for (int r = 0; r < N; r++) send_w(mkrow(base, r));
`ifdef FEEDER_BIAS_EN
    send_w(bias_row);
`endif
    chk("w_ready_drop", 64'(w_ready), 64'd0);
    if (abort_at >= 0) begin
      repeat (abort_at) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_load_w", 64'(load_w), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      wq.delete();
      tick();
      chk("abort_w_ready", 64'(w_ready), 64'd1);
    end else begin
      while (!a_ready && n < 40) begin tick(); n++; end
      chk("load_wait", 64'(a_ready), 64'd1);
      chk("load_len", 64'(ldcnt), 64'(2*N));
      for (int k = 0; k < N; k++) chk($sformatf("pe_row%0d", k), ch[2*k+1], mkrow(base, k));
      chk("w_col_left", 64'(wq.size()), 64'd0);
    end
  endtask

  initial begin
    logic [N*DW-1:0] va;
    logic [N*DW-1:0] vb;
    bias_row = {16'd40, 16'd30, 16'd20, 16'd10};
    rst_n = 1'b0; w_valid = 1'b0; w_data = '0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    tick(); tick();
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_load_w", 64'(load_w), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_w_col", w_col, 64'd0);
    chk("rst_a_row", a_row, 64'd0);
    chk("rst_vld", 64'(a_row_vld), 64'd0);
    chk("rst_sum_top", sum_top, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_w_ready0", 64'(w_ready), 64'd1);

    // Weight load, then a single skewed vector with a_last
    load_rows(0, -1);
    send_a({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b1);
    wait_done();

    // Fresh load; stream A, bubble, B(last) while w_valid is held (backpressure)
    load_rows(256, -1);
    va = {16'h0a03, 16'h0a02, 16'h0a01, 16'h0a00};
    vb = {16'h0b03, 16'h0b02, 16'h0b01, 16'h0b00};
    w_valid = 1'b1;
    w_data  = {16'hdead, 16'hdead, 16'hdead, 16'hdead};
    bp = 1'b1;
    send_a(va, 1'b1, 1'b0);
    send_a('0, 1'b0, 1'b0);
    send_a(vb, 1'b1, 1'b1);
    bp = 1'b0;
    w_valid = 1'b0;
    wait_done();

    // Reset during load cycle 3, then a clean load and one vector
    load_rows(512, 3);
    load_rows(768, -1);
    send_a({16'h00dd, 16'h00cc, 16'h00bb, 16'h00aa}, 1'b1, 1'b1);
    wait_done();

    tick(); tick();
    for (int r = 0; r < N; r++) chk($sformatf("lane%0d_left", r), 64'(lq[r].size()), 64'd0);
    chk("done_left", 64'(dq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
